// File: rtl/fir_tap_sequencer.sv
// Configuration/streaming controller for the 4-tap systolic FIR datapath.
// Optional beat counter port out_count is built when FIR_SEQ_STATS_EN is defined.
module fir_tap_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned LATENCY  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_coeff,
    input  logic              start,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              fir_ce,
    output logic [DATA_W-1:0] fir_x,
    output logic              fir_wload,
    output logic [DATA_W-1:0] fir_win,
    input  logic [DATA_W-1:0] fir_y,
`ifdef FIR_SEQ_STATS_EN
    output logic [31:0]       out_count,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned MAX_PH = (NUM_TAPS > LATENCY) ? NUM_TAPS : LATENCY;
    localparam int unsigned PH_W  = $clog2(MAX_PH + 1);

    if (LATENCY < NUM_TAPS - 1) begin : g_bad_latency
        $error("LATENCY must be >= NUM_TAPS-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [PH_W-1:0]    ph, ph_n;
    logic               loaded, loaded_n;
    logic [LATENCY-1:0] vpipe;
    logic [DATA_W-1:0]  shadow [NUM_TAPS];
    logic [CNT_W-1:0]   win_idx;
    logic               shadow_we;
    logic               pipe_adv;
    logic               pipe_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ph     <= '0;
            loaded <= 1'b0;
            vpipe  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ph     <= ph_n;
            loaded <= loaded_n;
            if (pipe_adv) begin
                for (int unsigned i = LATENCY - 1; i > 0; i--) begin
                    vpipe[i] <= vpipe[i-1];
                end
                vpipe[0] <= pipe_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && shadow_we) begin
            shadow[cnt] <= cfg_coeff;
        end
    end

    // Weights are shifted in last-first so PE_i ends up holding coefficient i.
    always_comb begin
        win_idx = CNT_W'((NUM_TAPS - 1) - 32'(ph));
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ph_n      = ph;
        loaded_n  = loaded;
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        fir_ce    = 1'b0;
        fir_x     = '0;
        fir_wload = 1'b0;
        fir_win   = '0;
        busy      = 1'b0;
        shadow_we = 1'b0;
        pipe_adv  = 1'b0;
        pipe_in   = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    shadow_we = 1'b1;
                    loaded_n  = 1'b0;
                    if (cnt == CNT_W'(NUM_TAPS - 1)) begin
                        cnt_n   = '0;
                        ph_n    = '0;
                        state_n = S_LOAD;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (start && loaded) begin
                    state_n = S_RUN;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                fir_wload = 1'b1;
                fir_ce    = 1'b1;
                fir_win   = shadow[win_idx];
                if (ph == PH_W'(NUM_TAPS - 1)) begin
                    loaded_n = 1'b1;
                    state_n  = S_RUN;
                end else begin
                    ph_n = ph + PH_W'(1);
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    fir_ce   = 1'b1;
                    fir_x    = s_data;
                    pipe_adv = 1'b1;
                    pipe_in  = 1'b1;
                end
                if (flush) begin
                    ph_n    = '0;
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy     = 1'b1;
                fir_ce   = 1'b1;
                pipe_adv = 1'b1;
                if (ph == PH_W'(LATENCY - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    ph_n = ph + PH_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // The valid pipe only moves with the datapath, so its tail lines up with fir_y.
    always_comb begin
        m_valid = pipe_adv & vpipe[LATENCY-1];
        m_data  = m_valid ? fir_y : '0;
    end

`ifdef FIR_SEQ_STATS_EN
    logic load_entry;

    always_comb begin
        load_entry = (state == S_IDLE) && (state_n == S_LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset || load_entry) begin
            out_count <= '0;
        end else if (m_valid && (out_count != '1)) begin
            out_count <= out_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural systolic datapath, vector table and scoreboard.
// Builds with or without FIR_SEQ_STATS_EN.
module tb_fir_tap_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned NT = 4;
    localparam int unsigned LAT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid, cfg_ready;
    logic [DW-1:0] cfg_coeff;
    logic          start, flush;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          fir_ce, fir_wload;
    logic [DW-1:0] fir_x, fir_win, fir_y;
    logic          busy;
`ifdef FIR_SEQ_STATS_EN
    logic [31:0]   out_count;
`endif

    fir_tap_sequencer #(.DATA_W(DW), .NUM_TAPS(NT), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_coeff(cfg_coeff),
        .start(start), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_data(m_data),
        .fir_ce(fir_ce), .fir_x(fir_x), .fir_wload(fir_wload), .fir_win(fir_win),
        .fir_y(fir_y),
`ifdef FIR_SEQ_STATS_EN
        .out_count(out_count),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural systolic datapath: weight chain, x history, LAT-deep result pipe.
    logic [DW-1:0] dp_w [NT];
    logic [DW-1:0] dp_h [NT];
    logic [DW-1:0] dp_y [LAT];

    always @(posedge clock) begin
        if (fir_ce) begin
            logic [DW-1:0] acc;
            if (fir_wload) begin
                for (int i = NT - 1; i > 0; i--) dp_w[i] <= dp_w[i-1];
                dp_w[0] <= fir_win;
            end
            acc = dp_w[0] * fir_x;
            for (int i = 1; i < NT; i++) acc = acc + dp_w[i] * dp_h[i-1];
            for (int i = NT - 1; i > 0; i--) dp_h[i] <= dp_h[i-1];
            dp_h[0] <= fir_x;
            for (int i = LAT - 1; i > 0; i--) dp_y[i] <= dp_y[i-1];
            dp_y[0] <= acc;
        end
    end

    always_comb fir_y = dp_y[LAT-1];

    initial begin
        for (int i = 0; i < NT; i++) begin
            dp_w[i] = '0;
            dp_h[i] = '0;
        end
        for (int i = 0; i < LAT; i++) dp_y[i] = '0;
    end

    int checks;
    int errors;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] coeff [NT];
    logic [DW-1:0] hist [NT];

    typedef struct {
        logic          cv;
        logic [DW-1:0] cc;
        logic          rdy;
        logic          wl;
        logic          ce;
        logic [DW-1:0] win;
        logic          bsy;
        logic          srdy;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        if (!reset) begin
            if (m_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL m_data_unexpected got %0d expected none at %0t", m_data, $time);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL m_data got %0d expected %0d at %0t", m_data, e, $time);
                    end
                end
            end else begin
                chk("m_data_idle", m_data, 32'd0);
            end
        end
    endtask

    task automatic half();
        @(negedge clock);
        monitor();
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        half();
        adv();
    endtask

    task automatic clr_hist();
        for (int i = 0; i < NT; i++) hist[i] = '0;
    endtask

    task automatic push_exp(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        y = '0;
        for (int i = 0; i < NT; i++) y = y + coeff[i] * hist[i];
        exp_q.push_back(y);
    endtask

    task automatic send(input logic [DW-1:0] x, input logic fl);
        s_valid = 1'b1;
        s_data  = x;
        flush   = fl;
        push_exp(x);
        half();
        chk("send_ce", 32'(fir_ce), 32'd1);
        chk("send_x", fir_x, x);
        adv();
        s_valid = 1'b0;
        s_data  = '0;
        flush   = 1'b0;
    endtask

    task automatic drain_checks();
        for (int i = 0; i < LAT; i++) begin
            half();
            chk("drain_ce", 32'(fir_ce), 32'd1);
            chk("drain_x", fir_x, 32'd0);
            chk("drain_s_ready", 32'(s_ready), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
            adv();
        end
        clr_hist();
    endtask

    task automatic idle_check();
        half();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        adv();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic load_coeffs(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                               input logic [DW-1:0] c2, input logic [DW-1:0] c3);
        coeff[0] = c0;
        coeff[1] = c1;
        coeff[2] = c2;
        coeff[3] = c3;
        for (int i = 0; i < NT; i++) begin
            cfg_valid = 1'b1;
            cfg_coeff = coeff[i];
            cyc();
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < NT; i++) cyc();
        clr_hist();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_coeff = '0;
        start = 1'b0;
        flush = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        clr_hist();

        tbl[0] = '{1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1};

        adv();
        adv();
        half();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_fir_ce", 32'(fir_ce), 32'd0);
        chk("rst_fir_wload", 32'(fir_wload), 32'd0);
        chk("rst_fir_x", fir_x, 32'd0);
        chk("rst_fir_win", fir_win, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        adv();
        reset = 1'b0;

        // Coefficient collection, LOAD shifting and RUN entry, one row per cycle.
        for (int i = 0; i < 9; i++) begin
            cfg_valid = tbl[i].cv;
            cfg_coeff = tbl[i].cc;
            half();
            chk($sformatf("tbl%0d_cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_wload", i), 32'(fir_wload), 32'(tbl[i].wl));
            chk($sformatf("tbl%0d_ce", i), 32'(fir_ce), 32'(tbl[i].ce));
            chk($sformatf("tbl%0d_win", i), fir_win, tbl[i].win);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].srdy));
            adv();
        end
        cfg_valid = 1'b0;
        coeff[0] = 32'd1;
        coeff[1] = 32'd2;
        coeff[2] = 32'd3;
        coeff[3] = 32'd4;
        clr_hist();

        // Impulse back-to-back, flush with the last beat.
        for (int j = 0; j < 10; j++) begin
            if (j < 6) begin
                s_valid = 1'b1;
                s_data  = (j == 0) ? 32'd1 : 32'd0;
                flush   = (j == 5);
                push_exp(s_data);
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
                flush   = 1'b0;
            end
            half();
            chk($sformatf("imp%0d_m_valid", j), 32'(m_valid), 32'(j >= 4));
            adv();
        end
        clr_hist();
        half();
        chk("imp_done_busy", 32'(busy), 32'd0);
`ifdef FIR_SEQ_STATS_EN
        chk("out_count", out_count, 32'd6);
`endif
        adv();

        // Gapped input: pipe frozen between beats.
        load_coeffs(32'd1, 32'd1, 32'd1, 32'd1);
        half();
        chk("run_s_ready", 32'(s_ready), 32'd1);
        adv();
        for (int j = 0; j < 10; j++) begin
            s_valid = (j % 2 == 0);
            s_data  = 32'd1;
            if (s_valid) push_exp(s_data);
            half();
            chk($sformatf("gap%0d_ce", j), 32'(fir_ce), 32'(s_valid));
            adv();
        end
        s_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drain_checks();
        idle_check();

        // Flush with the final beat, then restart with clean history.
        start_pulse();
        send(32'd5, 1'b0);
        send(32'd5, 1'b1);
        drain_checks();
        idle_check();
        start_pulse();
        send(32'd7, 1'b1);
        drain_checks();
        idle_check();

        // flush outside RUN is ignored.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle_check();

        // Reset during LOAD.
        for (int i = 0; i < NT; i++) begin
            cfg_valid = 1'b1;
            cfg_coeff = (i == 0) ? 32'd2 : 32'd0;
            cyc();
        end
        cfg_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        half();
        chk("rstload_busy", 32'(busy), 32'd0);
        chk("rstload_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rstload_wload", 32'(fir_wload), 32'd0);
        chk("rstload_ce", 32'(fir_ce), 32'd0);
        adv();
        start_pulse();
        half();
        chk("start_unloaded_busy", 32'(busy), 32'd0);
        adv();

        // Reset in RUN with pending valids.
        load_coeffs(32'd1, 32'd2, 32'd3, 32'd4);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        clr_hist();
        half();
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_m_valid", 32'(m_valid), 32'd0);
        chk("rstrun_s_ready", 32'(s_ready), 32'd0);
        chk("rstrun_m_data", m_data, 32'd0);
        adv();

        // Partial set: start ignored until all words arrive.
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1;
            cfg_coeff = 32'd1;
            cyc();
        end
        cfg_valid = 1'b0;
        start_pulse();
        half();
        chk("start_partial_busy", 32'(busy), 32'd0);
        adv();
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1;
            cfg_coeff = 32'd1;
            cyc();
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < NT; i++) cyc();
        for (int i = 0; i < NT; i++) coeff[i] = 32'd1;
        clr_hist();
        half();
        chk("partial_run_s_ready", 32'(s_ready), 32'd1);
        adv();

        // cfg beat held off during RUN/DRAIN, consumed on return to IDLE.
        cfg_valid = 1'b1;
        cfg_coeff = 32'd9;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
            adv();
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drain_checks();
        half();
        chk("held_cfg_ready", 32'(cfg_ready), 32'd1);
        adv();
        cfg_valid = 1'b0;
        half();
        chk("held_busy", 32'(busy), 32'd0);
        adv();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Controller that configures and sequences the 4-tap systolic FIR datapath. It collects coefficients over a valid/ready config port and shifts them into the PE weight chain. It then streams samples into the array with a clock enable and tags the filter outputs with valid. On a flush request it drains in-flight results. It sits between the upstream sample/config sources and the systolic filter instance.

Parameters:
DATA_W, 32, width of samples, coefficients and filter output (fp_32_t).
NUM_TAPS, 4, number of PEs / coefficients.
LATENCY, 4, enabled cycles from fir_x to the matching fir_y; must be >= NUM_TAPS-1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  coefficient word valid
cfg_ready  out  1  coefficient word accepted when both high
cfg_coeff  in  DATA_W  coefficient, tap 0 first
start  in  1  pulse: IDLE->RUN when coefficients loaded
flush  in  1  pulse: RUN->DRAIN
s_valid  in  1  input sample valid
s_ready  out  1  sample accepted when both high
s_data  in  DATA_W  input sample
m_valid  out  1  output sample valid (no backpressure)
m_data  out  DATA_W  filtered output, 0 when m_valid=0
fir_ce  out  1  datapath advance enable
fir_x  out  DATA_W  datapath sample input
fir_wload  out  1  datapath weight-shift mode
fir_win  out  DATA_W  weight shifted into PE0
fir_y  in  DATA_W  datapath output
busy  out  1  high in LOAD, RUN, DRAIN

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on posedge clock.
- Reset (any state, any cycle) sets:
  - state=IDLE, coefficient count=0, loaded=0, valid pipe cleared, stats cleared.
  - cfg_ready=1, s_ready=0, m_valid=0, m_data=0, fir_ce=0, fir_wload=0, fir_x=0, fir_win=0, busy=0.
- IDLE:
  - cfg_ready=1. Each accepted cfg word goes to shadow[count], count++, and clears loaded.
  - When count reaches NUM_TAPS: count=0, go to LOAD.
  - start with loaded=1 and no cfg beat in the same cycle: go to RUN. Otherwise start is ignored.
  - A partial coefficient set is retained across start and flush.
- LOAD (exactly NUM_TAPS cycles):
  - fir_wload=1, fir_ce=1, fir_x=0.
  - fir_win=shadow[NUM_TAPS-1-k] in load cycle k, so PE_i ends holding coeff i.
  - cfg_ready=0, s_ready=0.
  - On exit: loaded=1, go directly to RUN.
- RUN:
  - s_ready=1, cfg_ready=0 (cfg beats are held off, not dropped).
  - On an s_valid beat: fir_ce=1, fir_x=s_data, and a 1 is pushed into the LATENCY-deep valid pipe.
  - With no beat: fir_ce=0, fir_x=0, and the pipe holds.
  - The pipe advances only when fir_ce=1.
  - m_valid = fir_ce & pipe tail. m_data = fir_y when m_valid, else 0.
  - A sample accepted at edge t is emitted in the cycle of its LATENCY-th subsequent enabled edge. For back-to-back input, m_valid is high in cycle t+LATENCY.
- flush in RUN:
  - A sample beat in the same cycle is accepted first.
  - Then go to DRAIN. s_ready=0 from the next cycle.
- DRAIN (exactly LATENCY cycles):
  - fir_ce=1, fir_x=0, 0 pushed into the pipe.
  - m_valid follows the pipe tail, so all pending outputs emerge.
  - Then go to IDLE with loaded retained. The delay lines now hold zeros, so a later start begins with clean history.
- flush outside RUN and start outside IDLE are ignored.
- Arithmetic is done in the datapath. The controller never modifies sample or coefficient values.

Optional Feature:
- Macro: FIR_SEQ_STATS_EN.
- Defined:
  - Adds output out_count [31:0], counting m_valid beats.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset and on LOAD entry.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then cfg 1,2,3,4 -> cfg_ready=1 for 4 beats. LOAD lasts 4 cycles with fir_wload=1 and fir_win 4,3,2,1. Then busy=1, s_ready=1 in RUN.
- Coeffs 1,2,3,4, start, then impulse 1,0,0,0,0,0 back-to-back -> m_valid first at 4 cycles after the first beat. m_data 1,2,3,4,0,0 (filter model with ce).
- Coeffs all 1, input 1 every other cycle (s_valid toggling) -> fir_ce only on beats, valid pipe frozen in gaps. Outputs 1,2,3,4,4 on beat-aligned cycles; m_data=0 whenever m_valid=0.
- Flush asserted together with the last beat of input 5,5 (coeffs 1,1,1,1) -> last sample accepted, DRAIN 4 cycles with fir_x=0. All outputs 5,10 emitted, then IDLE with busy=0. start gives outputs with no stale history.
- Reset asserted in cycle 2 of LOAD, then in RUN with pending valids -> next cycle IDLE, all outputs 0, loaded=0. start is ignored until 4 new cfg words arrive.
- cfg_valid held high during RUN -> cfg_ready=0, word not consumed until IDLE. With FIR_SEQ_STATS_EN, out_count equals the number of m_valid beats (e.g. 6 after the impulse test).
